mesm6_alu_seq: RTL
==================

// Module: mesm6_alu_seq
// PURPOSE
// Parametrised multicycle ALU for the mesm6 datapath; successor to the single-width
// op-held ALU. Uses an explicit start/busy/done handshake. Latency is fixed per op.
// Adds the iterative BESM-6 ops ANX (CLZ), APX (PACK) and AUX (UNPACK), processed
// BITS_PER_CYCLE bits per clock. Sits between the control unit and accumulator/Y registers.
// PARAMETERS
// WIDTH           48  operand/result width; WIDTH >= 8
// BITS_PER_CYCLE  8   bits scanned per clock by CLZ/PACK/UNPACK; must divide WIDTH
// SHIFT_FIELD     7   width of shift exponent field taken from b[WIDTH-1 -: SHIFT_FIELD]
// PORTS
// clk      in   1                   rising-edge clock
// reset_n  in   1                   asynchronous active-low reset
// start    in   1                   request; sampled with op/a/b when busy=0
// op       in   `ALU_OP_WIDTH       operation, `ALU_* codes from mesm6_defines.sv
// a        in   WIDTH               operand A (accumulator)
// b        in   WIDTH               operand B (memory operand / mask / shift word)
// busy     out  1                   operation in progress; start ignored while 1
// done     out  1                   one-cycle pulse: result/y valid from this cycle
// illegal  out  1                   pulses with done when op is unsupported or `ALU_NOP
// result   out  WIDTH               main result, held until next accepted start
// y        out  WIDTH               low-order/auxiliary result, held likewise
// BEHAVIOUR
// - Reset (async, reset_n=0): FSM->IDLE; busy, done, illegal, result, y all 0.
// - FSM IDLE -> RUN on start&!busy (operands latched); RUN -> IDLE on last step.
//   done pulses on the last RUN cycle's edge; busy=1 from accept edge until done.
// - start while busy: ignored, no queueing. start in the done cycle: accepted.
// - Latency = cycles from accept edge to done=1:
//   AND/OR/XOR/SHIFT/COUNT = 1; ADD_CARRY_AROUND = 2; CLZ/PACK/UNPACK = WIDTH/BITS_PER_CYCLE.
// - AND: r=a&b, y=0. OR: r=a|b, y=0. XOR: r=a^b, y=a.
// - ADD_CARRY_AROUND: cycle 1: s=a+b (WIDTH+1 bits). Cycle 2: r=s[W-1:0]+s[W]; y=0.
//   The end-around +1 never carries again.
// - SHIFT: n=b[WIDTH-1 -: SHIFT_FIELD].
//   n>=64: right shift by k=n-64, {r,y}={a,0}>>k.
//   n<64: left shift by k=64-n, {y,r}={0,a}<<k.
//   k=0 gives r=a, y=0.
// - COUNT: r=popcount(a), zero-extended; y=0. The control unit follows with ADD_CARRY_AROUND for ACX.
// - CLZ: scan from MSB. a!=0: r=clz(a)+1, y=(a<<(clz+1)) truncated to WIDTH.
//   a==0: r=0, y=0. Full step count is used even if the 1 is found early.
// - PACK: bits of a at positions where b=1 are gathered, order kept, into r LSB-up;
//   remaining r bits 0; y=0.
// - UNPACK: low bits of a, LSB first, are scattered to positions where b=1;
//   other r bits 0; y=0.
// - PACK/UNPACK scan LSB->MSB, BITS_PER_CYCLE per step.
// - NOP/unknown op: latency 1, r=0, y=0, illegal=1 with done.
// - result/y update only at done; intermediate state is internal and not visible.
// - Reset mid-operation: abort immediately, no done pulse, outputs 0.
// TESTING (WIDTH=48, BITS_PER_CYCLE=8)
// - ADD_CARRY_AROUND a=48'hFFFF_FFFF_FFFF b=1 -> done 2 clk after accept.
//   result=1, y=0. Then a=5, b=3 -> result=8.
// - SHIFT a=1, b[47:41]=65 -> result=0, y=48'h8000_0000_0000.
//   a=48'h8000_0000_0001, b[47:41]=63 -> result=2, y=1.
//   b[47:41]=64 -> result=a, y=0.
// - COUNT a=48'h0000_0000_00FF -> result=8, latency 1.
//   XOR a=48'hF0, b=48'hFF -> result=48'h0F, y=48'hF0.
// - CLZ a=48'h0010_0000_0000 -> result=12, y=0, done 6 clk after accept.
//   a=48'h0000_0000_0001 -> result=48, y=0. a=0 -> result=0.
// - PACK a=48'hA5, b=48'hF0 -> result=48'hA.
//   UNPACK a=48'h5, b=48'hF0 -> result=48'h50. Both latency 6.
// - Control: start during CLZ busy -> ignored, result unchanged.
//   reset_n=0 at step 3 -> busy/done/result/y=0, no done pulse.
//   op=`ALU_NOP -> done+illegal after 1 clk.

Source files
------------

// File: rtl/mesm6_alu_seq.sv
// mesm6_alu_seq: multicycle mesm6 ALU with start/busy/done handshake and iterative CLZ/PACK/UNPACK
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`define ALU_NOP 4'd0
`define ALU_AND 4'd1
`define ALU_OR 4'd2
`define ALU_XOR 4'd3
`define ALU_ADD_CARRY_AROUND 4'd4
`define ALU_SHIFT 4'd5
`define ALU_COUNT 4'd6
`define ALU_CLZ 4'd7
`define ALU_PACK 4'd8
`define ALU_UNPACK 4'd9
`endif
module mesm6_alu_seq #(
    parameter int WIDTH = 48,
    parameter int BITS_PER_CYCLE = 8,
    parameter int SHIFT_FIELD = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [`ALU_OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     busy,
    output logic                     done,
    output logic                     illegal,
    output logic [WIDTH-1:0]         result,
    output logic [WIDTH-1:0]         y
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q;
    logic [`ALU_OP_WIDTH-1:0] op_q;
    logic [WIDTH-1:0] a_q, b_q, sh_q, acc_q, acc_d, result_q, y_q, r_d, y_d;
    logic carry_q, found_q, found_d, done_q, ill_q, ill_d;
    logic [CW-1:0] cnt_q, k_q, k_d, pos_q, lz, pop;
    logic [BITS_PER_CYCLE-1:0] chunk;
    logic [2*WIDTH-1:0] shl, shr;
    int sk;

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign illegal = ill_q;
    assign result = result_q;
    assign y = y_q;

    // Index of the final RUN cycle for each op: the cycle count minus one.
    function automatic logic [CW-1:0] last_step(input logic [`ALU_OP_WIDTH-1:0] o);
        return (o == `ALU_ADD_CARRY_AROUND) ? CW'(1) :
               (o == `ALU_CLZ || o == `ALU_PACK || o == `ALU_UNPACK) ? CW'(STEPS - 1) : '0;
    endfunction

    // One scan step: a BITS_PER_CYCLE-wide slice of CLZ (from MSB) or PACK/UNPACK (from LSB).
    always_comb begin
        k_d = k_q;
        acc_d = acc_q;
        found_d = found_q;
        chunk = sh_q[WIDTH-1 -: BITS_PER_CYCLE];
        lz = CW'(BITS_PER_CYCLE);
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (chunk[i]) lz = CW'(BITS_PER_CYCLE - 1 - i);
            if (op_q == `ALU_PACK && b_q[pos_q + CW'(i)]) begin
                acc_d[k_d] = a_q[pos_q + CW'(i)];
                k_d = k_d + 1'b1;
            end
            if (op_q == `ALU_UNPACK && b_q[pos_q + CW'(i)]) begin
                acc_d[pos_q + CW'(i)] = a_q[k_d];
                k_d = k_d + 1'b1;
            end
        end
        if (op_q == `ALU_CLZ) begin
            found_d = found_q | (|chunk);
            k_d = found_q ? k_q : k_q + lz;
        end
    end

    // Final result/y for the op, taken at the done edge.
    always_comb begin
        sk = int'(b_q[WIDTH-1 -: SHIFT_FIELD]);
        shr = {a_q, {WIDTH{1'b0}}} >> (sk - 64);
        shl = {{WIDTH{1'b0}}, a_q} << (64 - sk);
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + CW'(a_q[i]);
        r_d = '0;
        y_d = '0;
        ill_d = 1'b0;
        case (op_q)
            `ALU_AND: r_d = a_q & b_q;
            `ALU_OR: r_d = a_q | b_q;
            `ALU_XOR: begin
                r_d = a_q ^ b_q;
                y_d = a_q;
            end
            `ALU_ADD_CARRY_AROUND: r_d = acc_q + WIDTH'(carry_q);
            `ALU_SHIFT: {r_d, y_d} = (sk >= 64) ? shr : {shl[WIDTH-1:0], shl[2*WIDTH-1:WIDTH]};
            `ALU_COUNT: r_d = WIDTH'(pop);
            `ALU_CLZ: begin
                r_d = found_d ? WIDTH'(k_d + 1'b1) : '0;
                y_d = found_d ? a_q << (k_d + 1'b1) : '0;
            end
            `ALU_PACK, `ALU_UNPACK: r_d = acc_d;
            default: ill_d = 1'b1;
        endcase
    end

    // Handshake FSM: latch operands on accept, step until the last cycle, then publish.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            sh_q <= '0;
            acc_q <= '0;
            carry_q <= 1'b0;
            found_q <= 1'b0;
            cnt_q <= '0;
            k_q <= '0;
            pos_q <= '0;
            done_q <= 1'b0;
            ill_q <= 1'b0;
            result_q <= '0;
            y_q <= '0;
        end else begin
            done_q <= 1'b0;
            ill_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    op_q <= op;
                    a_q <= a;
                    b_q <= b;
                    sh_q <= a;
                    acc_q <= '0;
                    carry_q <= 1'b0;
                    found_q <= 1'b0;
                    k_q <= '0;
                    pos_q <= '0;
                    cnt_q <= last_step(op);
                    state_q <= RUN;
                end
            end else begin
                if (op_q == `ALU_ADD_CARRY_AROUND) {carry_q, acc_q} <= {1'b0, a_q} + {1'b0, b_q};
                else acc_q <= acc_d;
                k_q <= k_d;
                found_q <= found_d;
                sh_q <= sh_q << BITS_PER_CYCLE;
                pos_q <= pos_q + CW'(BITS_PER_CYCLE);
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    result_q <= r_d;
                    y_q <= y_d;
                    done_q <= 1'b1;
                    ill_q <= ill_d;
                    state_q <= IDLE;
                end
            end
        end
    end
endmodule
